// File: rtl/writeback_arbiter.sv
// Three-way round-robin writeback arbiter: grants one of ALU/LSU/CSR per cycle into a
// one-entry output register that drives the register-file write port and scoreboard release.
module writeback_arbiter (
    input  logic             clk,
    input  logic             nrst,
    input  logic [2:0]       req_valid,
    input  logic [2:0][4:0]  req_rd,
    input  logic [2:0][31:0] req_data,
    output logic [2:0]       req_ready,
    input  logic             wb_hold,
    output logic             wb_en,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic             clr_en,
    output logic [4:0]       clr_rd,
    output logic [1:0]       grant_id
);

    function automatic logic [1:0] mod3_inc(input logic [1:0] v);
        case (v)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    logic [1:0]  r_rr_ptr;
    logic        r_out_valid;
    logic [4:0]  r_out_rd;
    logic [31:0] r_out_data;
    logic [1:0]  r_out_id;

    logic [1:0]  w_prio [3];
    logic [3:0]  w_valid_pad;
    logic        w_accept;
    logic [1:0]  w_grant_idx;
    logic [4:0]  w_sel_rd;
    logic [31:0] w_sel_data;

    // Priority slots: rr_ptr first, then the next two requesters modulo 3.
    always_comb begin
        w_prio[0] = (r_rr_ptr == 2'd3) ? 2'd0 : r_rr_ptr;
        w_prio[1] = mod3_inc(w_prio[0]);
        w_prio[2] = mod3_inc(w_prio[1]);
    end

    assign w_valid_pad = {1'b0, req_valid};

    // Scan from lowest priority upward so the highest-priority valid requester wins.
    always_comb begin
        w_accept    = 1'b0;
        w_grant_idx = 2'd0;
        if (nrst && !wb_hold) begin
            for (int k = 2; k >= 0; k--) begin
                if (w_valid_pad[w_prio[k]]) begin
                    w_accept    = 1'b1;
                    w_grant_idx = w_prio[k];
                end
            end
        end
    end

    always_comb begin
        req_ready = 3'b000;
        for (int i = 0; i < 3; i++) begin
            req_ready[i] = w_accept && (w_grant_idx == 2'(i));
        end
    end

    always_comb begin
        case (w_grant_idx)
            2'd1: begin
                w_sel_rd   = req_rd[1];
                w_sel_data = req_data[1];
            end
            2'd2: begin
                w_sel_rd   = req_rd[2];
                w_sel_data = req_data[2];
            end
            default: begin
                w_sel_rd   = req_rd[0];
                w_sel_data = req_data[0];
            end
        endcase
    end

    // The output entry retires every unheld cycle; a same-edge acceptance replaces it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rr_ptr    <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_rd    <= 5'd0;
            r_out_data  <= 32'd0;
            r_out_id    <= 2'd0;
        end else if (!wb_hold) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_rr_ptr   <= mod3_inc(w_grant_idx);
                r_out_rd   <= w_sel_rd;
                r_out_data <= w_sel_data;
                r_out_id   <= w_grant_idx;
            end
        end
    end

    // x0 results are accepted for fairness but never written or released.
    assign wb_en    = r_out_valid && !wb_hold && (r_out_rd != 5'd0);
    assign wb_rd    = r_out_rd;
    assign wb_data  = r_out_data;
    assign clr_en   = wb_en;
    assign clr_rd   = wb_rd;
    assign grant_id = r_out_valid ? r_out_id : 2'd0;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!nrst) $onehot0(req_ready));
    a_ready_valid:  assert property (@(posedge clk) disable iff (!nrst) (req_ready & ~req_valid) == 3'b000);
    a_hold_nogrant: assert property (@(posedge clk) disable iff (!nrst) wb_hold |-> (req_ready == 3'b000));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed table-driven bench for writeback_arbiter, plus hand sequences for reset behaviour.
module tb_writeback_arbiter;

    typedef struct {
        logic             hold;
        logic [2:0]       valid;
        logic [2:0][4:0]  rd;
        logic [2:0][31:0] data;
        logic [2:0]       exp_ready;
        logic             exp_en;
        logic [4:0]       exp_rd;
        logic [31:0]      exp_data;
        logic [1:0]       exp_gid;
    } vec_t;

    localparam logic [31:0] D1 = 32'h1000_0001;
    localparam logic [31:0] D2 = 32'h2000_0002;
    localparam logic [31:0] D3 = 32'h3000_0003;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic [2:0]       req_valid;
    logic [2:0][4:0]  req_rd;
    logic [2:0][31:0] req_data;
    logic [2:0]       req_ready;
    logic             wb_hold;
    logic             wb_en;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;
    logic             clr_en;
    logic [4:0]       clr_rd;
    logic [1:0]       grant_id;

    int n_cmp = 0;
    int n_err = 0;
    vec_t tbl[$];

    writeback_arbiter dut (
        .clk       (clk),
        .nrst      (nrst),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wb_hold   (wb_hold),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .clr_en    (clr_en),
        .clr_rd    (clr_rd),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic hold, input logic [2:0] valid,
                                input logic [4:0] rd0, input logic [4:0] rd1, input logic [4:0] rd2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [2:0] ready, input logic en, input logic [4:0] wrd,
                                input logic [31:0] wdata, input logic [1:0] gid);
        vec_t v;
        v.hold      = hold;
        v.valid     = valid;
        v.rd[0]     = rd0;
        v.rd[1]     = rd1;
        v.rd[2]     = rd2;
        v.data[0]   = d0;
        v.data[1]   = d1;
        v.data[2]   = d2;
        v.exp_ready = ready;
        v.exp_en    = en;
        v.exp_rd    = wrd;
        v.exp_data  = wdata;
        v.exp_gid   = gid;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic hold, input logic [2:0] valid,
                         input logic [2:0][4:0] rd, input logic [2:0][31:0] data);
        wb_hold   = hold;
        req_valid = valid;
        req_rd    = rd;
        req_data  = data;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ready"}, 32'(req_ready), 32'd0);
        check({tag, " wb_en"}, 32'(wb_en), 32'd0);
        check({tag, " clr_en"}, 32'(clr_en), 32'd0);
        check({tag, " wb_rd"}, 32'(wb_rd), 32'd0);
        check({tag, " wb_data"}, wb_data, 32'd0);
        check({tag, " grant_id"}, 32'(grant_id), 32'd0);
    endtask

    // Inputs change on the falling edge; checks land 1 time unit later, before the next rising edge.
    task automatic apply(input int idx, input vec_t v);
        string t;
        @(negedge clk);
        drive(v.hold, v.valid, v.rd, v.data);
        #1;
        t = $sformatf("v%0d", idx);
        check({t, " req_ready"}, 32'(req_ready), 32'(v.exp_ready));
        check({t, " wb_en"}, 32'(wb_en), 32'(v.exp_en));
        check({t, " clr_en"}, 32'(clr_en), 32'(v.exp_en));
        check({t, " grant_id"}, 32'(grant_id), 32'(v.exp_gid));
        if (v.exp_en) begin
            check({t, " wb_rd"}, 32'(wb_rd), 32'(v.exp_rd));
            check({t, " clr_rd"}, 32'(clr_rd), 32'(v.exp_rd));
            check({t, " wb_data"}, wb_data, v.exp_data);
        end
    endtask

    initial begin
        // Three-way contention from reset
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0,               3'b000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3'b111, 1, 2, 3, D1, D2, D3,            3'b001, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3'b111, 1, 2, 3, D1, D2, D3,            3'b010, 1, 1, D1, 0));
        tbl.push_back(mk(0, 3'b111, 1, 2, 3, D1, D2, D3,            3'b100, 1, 2, D2, 1));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0,               3'b000, 1, 3, D3, 2));
        // rd = 0 accepted, pointer advances, no write
        tbl.push_back(mk(0, 3'b001, 0, 0, 0, 32'h55, 0, 0,          3'b001, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3'b011, 4, 9, 0, 32'h44, 32'h99, 0,     3'b010, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0,               3'b000, 1, 9, 32'h99, 1));
        // Single request
        tbl.push_back(mk(0, 3'b001, 5, 0, 0, 32'hDEADBEEF, 0, 0,    3'b001, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0,               3'b000, 1, 5, 32'hDEADBEEF, 0));
        // Same rd from ALU and LSU with rr_ptr = 1
        tbl.push_back(mk(0, 3'b011, 7, 7, 0, 32'h1, 32'h2, 0,       3'b010, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3'b001, 7, 0, 0, 32'h1, 0, 0,           3'b001, 1, 7, 32'h2, 1));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0,               3'b000, 1, 7, 32'h1, 0));
        // LSU accepted then held for three cycles
        tbl.push_back(mk(0, 3'b010, 0, 12, 0, 0, 32'hCAFE0012, 0,   3'b010, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3'b001, 3, 0, 0, 32'h0A0A0003, 0, 0,    3'b000, 0, 0, 0, 1));
        tbl.push_back(mk(1, 3'b001, 3, 0, 0, 32'h0A0A0003, 0, 0,    3'b000, 0, 0, 0, 1));
        tbl.push_back(mk(1, 3'b001, 3, 0, 0, 32'h0A0A0003, 0, 0,    3'b000, 0, 0, 0, 1));
        tbl.push_back(mk(0, 3'b001, 3, 0, 0, 32'h0A0A0003, 0, 0,    3'b001, 1, 12, 32'hCAFE0012, 1));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0,               3'b000, 1, 3, 32'h0A0A0003, 0));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0,               3'b000, 0, 0, 0, 0));
        // Rotation starting from rr_ptr = 1, wrapping 2 -> 0
        tbl.push_back(mk(0, 3'b111, 1, 2, 3, D1, D2, D3,            3'b010, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3'b111, 1, 2, 3, D1, D2, D3,            3'b100, 1, 2, D2, 1));
        tbl.push_back(mk(0, 3'b111, 1, 2, 3, D1, D2, D3,            3'b001, 1, 3, D3, 2));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0,               3'b000, 1, 1, D1, 0));

        // Reset held across a rising edge with all requesters valid
        drive(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {D3, D2, D1});
        #7;
        check_all_zero("reset");
        @(negedge clk);
        nrst = 1'b1;
        drive(1'b0, 3'b000, '0, '0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(i, tbl[i]);
        end

        // Mid-operation reset: the captured LSU entry must never be written
        @(negedge clk);
        drive(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {D3, D2, D1});
        #1;
        check("pre-reset req_ready", 32'(req_ready), 32'b010);
        @(posedge clk);
        #1;
        check("pre-reset wb_en", 32'(wb_en), 32'd1);
        nrst = 1'b0;
        #1;
        check_all_zero("mid-reset");
        @(posedge clk);
        #1;
        check_all_zero("mid-reset edge");
        @(negedge clk);
        nrst = 1'b1;
        #1;
        check("post-reset wb_en", 32'(wb_en), 32'd0);
        check("post-reset grant_id", 32'(grant_id), 32'd0);
        check("post-reset req_ready", 32'(req_ready), 32'b001);
        @(posedge clk);
        #1;
        check("post-reset first wb_en", 32'(wb_en), 32'd1);
        check("post-reset first wb_rd", 32'(wb_rd), 32'd1);
        check("post-reset first wb_data", wb_data, D1);
        check("post-reset first grant_id", 32'(grant_id), 32'd0);
        @(negedge clk);
        drive(1'b0, 3'b000, '0, '0);
        #1;
        check("post-reset next req_ready", 32'(req_ready), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset, as listed in REQ-002 and REQ-003.
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: nrst  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: req_valid  in  3  per-requester result valid; bit0 ALU, bit1 LSU, bit2 CSR/MULDIV.
REQ-005 SHALL have port: req_rd  in  3x5  per-requester destination register.
REQ-006 SHALL have port: req_data  in  3x32  per-requester result data.
REQ-007 SHALL have port: req_ready  out  3  one-hot grant; acceptance occurs when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-008 SHALL have port: wb_hold  in  1  freezes writeback, e.g. during exception commit.
REQ-009 SHALL have port: wb_en  out  1  register-file write enable.
REQ-010 SHALL have port: wb_rd  out  5  register-file write address.
REQ-011 SHALL have port: wb_data  out  32  register-file write data.
REQ-012 SHALL have port: clr_en  out  1  scoreboard pending-bit release strobe.
REQ-013 SHALL have port: clr_rd  out  5  scoreboard entry to release.
REQ-014 SHALL have port: grant_id  out  2  source of the current output-register entry (0..2).

Function
REQ-015 SHALL keep a round-robin pointer rr_ptr (2 bits, values 0..2).
- Priority order: rr_ptr, rr_ptr+1, rr_ptr+2, all mod 3.
REQ-016 SHALL assert req_ready combinationally, one-hot, for the highest-priority requester with req_valid high, when wb_hold is low.
- Otherwise req_ready SHALL be 3'b000.
REQ-017 SHALL never assert req_ready for a requester whose req_valid is low.
REQ-018 SHALL update rr_ptr on acceptance from requester i to (i+1) mod 3, wrapping 2->0.
- rr_ptr SHALL hold when nothing is accepted.
REQ-019 SHALL capture req_rd/req_data of the accepted requester into a one-entry output register (valid, rd, data, id) at the accepting edge.
- Latency: accepted at edge N; wb_en high during cycle N+1.
REQ-020 SHALL drive wb_en = out_valid && !wb_hold && (out_rd != 0).
REQ-021 SHALL drive clr_en = wb_en and clr_rd = wb_rd in the same cycle.
REQ-022 SHALL retire the output register every cycle in which wb_hold is low.
- With no acceptance on that edge, out_valid SHALL go low.
- A new acceptance on that edge SHALL overwrite the entry; back-to-back throughput is 1 per cycle.
REQ-023 SHALL, while wb_hold is high:
- keep the output register unchanged;
- keep rr_ptr unchanged;
- grant nothing.
- The held entry SHALL be written in the first cycle after wb_hold falls.
REQ-024 SHALL accept an entry with rd = 0 and advance rr_ptr, but SHALL assert neither wb_en nor clr_en for it.
REQ-025 SHALL, when two requesters present the same rd in one cycle, follow REQ-015 with no special handling.
- The loser is written in a later cycle, in grant order.
REQ-026 SHALL bound the wait of any continuously-valid requester to at most 2 grants to other requesters while wb_hold is low.
REQ-027 SHALL drive grant_id = out_id, and 0 when out_valid is low.

Reset
REQ-028 SHALL, while nrst is low, asynchronously clear: rr_ptr = 0, out_valid = 0, out_rd = 0, out_data = 0, out_id = 0.
REQ-029 SHALL hold outputs while nrst is low at: wb_en = 0, clr_en = 0, wb_rd = 0, wb_data = 0, grant_id = 0, req_ready = 0.
REQ-030 SHALL discard an output-register entry captured before a mid-operation reset.
- No wb_en for that entry after nrst rises.
REQ-031 SHALL resume granting in the first cycle after nrst rises, starting from ALU priority.

Verification
REQ-032 SHALL cover single request: ALU valid, rd=5, data=0xDEADBEEF at edge N -> wb_en=1, wb_rd=5, wb_data=0xDEADBEEF, clr_en=1, clr_rd=5 in cycle N+1, then wb_en=0.
REQ-033 SHALL cover all three valid for 3 edges from reset -> grants ALU, LSU, CSR in order; rr_ptr 0->1->2->0; three consecutive wb_en cycles.
REQ-034 SHALL cover same rd=7 from ALU (0x1) and LSU (0x2), rr_ptr=1 -> LSU written first (0x2), ALU next cycle (0x1).
REQ-035 SHALL cover LSU accepted, then wb_hold high 3 cycles -> wb_en=0 and req_ready=0 throughout; LSU data written in the first cycle after release.
REQ-036 SHALL cover ALU request with rd=0 -> req_ready[0]=1, rr_ptr advances to 1, wb_en=0, clr_en=0.
REQ-037 SHALL cover nrst pulsed low while out_valid=1 -> no wb_en after release; first post-reset grant goes to ALU when all are valid.
